mem_port_arbiter: RTL

Shares the single data-memory port between two requesters: port 0 (core load/store stage) and port 1 (debug/DMA master). Each cycle it grants at most one request using round-robin priority, drives the memory's address/width/write controls combinationally, and routes the one-cycle-latency read data back to the requester that issued the read. A lock mechanism lets one requester hold the port across an atomic read-modify-write sequence. A watchdog bounds how long the port can stay locked.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 19 +
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: request struct, access width, arbiter state.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LOCK_CNT_W = 8;
    localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            write;
        mem_width_t      width;
        logic            sign_extend;
        logic [XLEN-1:0] w_data;
        logic            lock;
    } mem_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCKED0 = 2'd1,
        ARB_LOCKED1 = 2'd2
    } arb_state_t;

    // Saturating increment for the lock watchdog counter.
    function automatic logic [LOCK_CNT_W-1:0] sat_inc(input logic [LOCK_CNT_W-1:0] v);
        return (v == LOCK_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle: two request ports with per-port ready and read responses.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    mem_req_t [1:0]  req;
    logic [1:0]      rsp_valid;
    logic [XLEN-1:0] rsp_data;

    // Requesters drive requests and observe grants/responses.
    modport master (
        output req_valid,
        output req,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // The arbiter consumes requests and produces grants/responses.
    modport slave (
        input  req_valid,
        input  req,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin selector: one-hot grant, ties go to the port opposite last_grant.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Pick the single valid port, or alternate on a tie.
    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between two requesters with round-robin arbitration,
// lock support for read-modify-write sequences and a lock watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned lock_timeout = 16
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                lock_abort,
    output logic [XLEN-1:0]     mem_addr,
    output mem_width_t          mem_r_width,
    output logic                mem_r_sign_extend,
    output logic [XLEN-1:0]     mem_w_data,
    output mem_width_t          mem_w_width,
    output logic                mem_w_enable,
    input  logic [XLEN-1:0]     mem_r_data
);

    localparam logic [LOCK_CNT_W-1:0] TIMEOUT_LAST = LOCK_CNT_W'(lock_timeout - 1);

    arb_state_t            state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_port_q, pend_port_d;

    logic [1:0] eligible;
    logic [1:0] grant;
    logic       fire;
    logic       sel;
    mem_req_t   sel_req;

    // Mask requests by lock ownership; nothing is eligible while in reset.
    always_comb begin
        eligible = 2'b00;
        if (!reset) begin
            unique case (state_q)
                ARB_IDLE:    eligible = bus.req_valid;
                ARB_LOCKED0: eligible = bus.req_valid & 2'b01;
                ARB_LOCKED1: eligible = bus.req_valid & 2'b10;
                default:     eligible = 2'b00;
            endcase
        end
    end

    rr_pick2 u_pick (
        .valid      (eligible),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign bus.req_ready = grant;
    assign fire          = |grant;
    assign sel           = grant[1];
    assign sel_req       = bus.req[sel];

    // Drive the memory port from the granted request, or idle defaults.
    always_comb begin
        mem_addr          = '0;
        mem_r_width       = WIDTH_WORD;
        mem_r_sign_extend = 1'b0;
        mem_w_data        = '0;
        mem_w_width       = WIDTH_WORD;
        mem_w_enable      = 1'b0;
        if (fire) begin
            mem_addr          = sel_req.addr;
            mem_r_width       = sel_req.width;
            mem_r_sign_extend = sel_req.sign_extend;
            mem_w_data        = sel_req.w_data;
            mem_w_width       = sel_req.width;
            mem_w_enable      = sel_req.write;
        end
    end

    // Read data returns one cycle after issue to whichever port issued the read.
    assign bus.rsp_valid = {pend_valid_q & pend_port_q, pend_valid_q & ~pend_port_q}
                           & {2{~reset}};
    assign bus.rsp_data  = mem_r_data;

    // Next-state: lock entry/exit, watchdog release, grant history and pending read.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = fire ? sel : last_grant_q;
        pend_valid_d = fire && !sel_req.write;
        pend_port_d  = fire ? sel : pend_port_q;
        lock_abort   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (fire && sel_req.lock) begin
                    state_d    = sel ? ARB_LOCKED1 : ARB_LOCKED0;
                    lock_cnt_d = '0;
                end
            end
            ARB_LOCKED0, ARB_LOCKED1: begin
                lock_cnt_d = sat_inc(lock_cnt_q);
                if (fire && !sel_req.lock) begin
                    state_d = ARB_IDLE;
                end else if (!reset && lock_cnt_q == TIMEOUT_LAST) begin
                    // A transfer granted this cycle still completes; only the lock is dropped.
                    state_d    = ARB_IDLE;
                    lock_abort = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers with synchronous reset; last_grant=1 lets port 0 win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_port_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
        end
    end

endmodule
